// File: rtl/dram_arb_pkg.sv
// Shared types and defaults for the two-port DRAM arbiter.
// The owner enumeration doubles as the grant encoding: the picker
// returns the port that wins this cycle, or OWNER_IDLE for no grant.
package dram_arb_pkg;

    localparam int AW_DEFAULT        = 8;
    localparam int DW_DEFAULT        = 16;
    localparam int MAX_BURST_DEFAULT = 4;

    // Encoding of the tie-break priority bit.
    localparam logic PRIO_A = 1'b0;
    localparam logic PRIO_B = 1'b1;

    typedef enum logic [1:0] {
        OWNER_IDLE = 2'd0,
        OWNER_A    = 2'd1,
        OWNER_B    = 2'd2
    } owner_t;

    // Burst counter increment that sticks at the limit.
    function automatic logic [3:0] sat_inc(input logic [3:0] value,
                                           input logic [3:0] limit);
        if (value >= limit) begin
            return limit;
        end
        return value + 4'd1;
    endfunction

endpackage

// File: rtl/dram_arb_pick.sv
// Purely combinational grant picker for the two-port DRAM arbiter.
// Given last cycle's owner, its burst count, the idle tie-break bit and the
// two request lines, returns the port to grant this cycle.
module dram_arb_pick
    import dram_arb_pkg::*;
#(
    parameter int MAX_BURST = MAX_BURST_DEFAULT
) (
    input  owner_t     owner,
    input  logic [3:0] cnt,
    input  logic       prio,
    input  logic       a_req,
    input  logic       b_req,
    output owner_t     grant
);

    localparam logic [3:0] BURST_LIM = 4'(MAX_BURST);

    // The current owner keeps the port until its burst is spent and the other
    // side is waiting; an owner that stops requesting hands over at once.
    always_comb begin
        grant = OWNER_IDLE;
        unique case (owner)
            OWNER_A: begin
                if (a_req) begin
                    if (!b_req || (cnt < BURST_LIM)) begin
                        grant = OWNER_A;
                    end else begin
                        grant = OWNER_B;
                    end
                end else if (b_req) begin
                    grant = OWNER_B;
                end
            end
            OWNER_B: begin
                if (b_req) begin
                    if (!a_req || (cnt < BURST_LIM)) begin
                        grant = OWNER_B;
                    end else begin
                        grant = OWNER_A;
                    end
                end else if (a_req) begin
                    grant = OWNER_A;
                end
            end
            default: begin
                if (a_req && b_req) begin
                    grant = (prio == PRIO_B) ? OWNER_B : OWNER_A;
                end else if (a_req) begin
                    grant = OWNER_A;
                end else if (b_req) begin
                    grant = OWNER_B;
                end
            end
        endcase
    end

endmodule

// File: rtl/dram_port_arbiter.sv
// Two-port arbiter in front of a single-port synchronous RAM.
// Port A is the processor, port B the loader/debug path. Grants are issued
// combinationally in the request cycle; reads return one cycle later.
//
//   state      | meaning
//   -----------+-----------------------------------------------
//   OWNER_IDLE | no grant last cycle; ties resolved by prio
//   OWNER_A    | port A was granted last cycle, cnt = run length
//   OWNER_B    | port B was granted last cycle, cnt = run length
module dram_port_arbiter
    import dram_arb_pkg::*;
#(
    parameter int AW        = AW_DEFAULT,
    parameter int DW        = DW_DEFAULT,
    parameter int MAX_BURST = MAX_BURST_DEFAULT
) (
    input  logic          clock,
    input  logic          reset,

    input  logic          a_req,
    input  logic          a_we,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_wdata,
    output logic          a_gnt,
    output logic          a_rvalid,
    output logic [DW-1:0] a_rdata,

    input  logic          b_req,
    input  logic          b_we,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_wdata,
    output logic          b_gnt,
    output logic          b_rvalid,
    output logic [DW-1:0] b_rdata,

    output logic [AW-1:0] mem_address,
    output logic [DW-1:0] mem_data,
    output logic          mem_wren,
    input  logic [DW-1:0] mem_q
);

    localparam logic [3:0] BURST_LIM = 4'(MAX_BURST);

    owner_t     owner;
    owner_t     owner_nxt;
    owner_t     pick;
    owner_t     grant;
    logic [3:0] cnt;
    logic [3:0] cnt_nxt;
    logic       prio;
    logic       prio_nxt;
    logic       a_rv_q;
    logic       b_rv_q;

    dram_arb_pick #(
        .MAX_BURST (MAX_BURST)
    ) u_pick (
        .owner (owner),
        .cnt   (cnt),
        .prio  (prio),
        .a_req (a_req),
        .b_req (b_req),
        .grant (pick)
    );

    // Grants are forced off while reset is high so no RAM access can start.
    always_comb begin
        grant = pick;
        if (reset) begin
            grant = OWNER_IDLE;
        end
        a_gnt = (grant == OWNER_A);
        b_gnt = (grant == OWNER_B);
    end

    // RAM port follows the granted port; with no grant it shows port A idle.
    always_comb begin
        mem_address = a_addr;
        mem_data    = a_wdata;
        mem_wren    = 1'b0;
        if (grant == OWNER_B) begin
            mem_address = b_addr;
            mem_data    = b_wdata;
            mem_wren    = b_we;
        end else if (grant == OWNER_A) begin
            mem_wren    = a_we;
        end
    end

    // Next owner, burst length and tie-break bit from this cycle's grant.
    always_comb begin
        owner_nxt = owner;
        cnt_nxt   = cnt;
        prio_nxt  = prio;
        if (grant == OWNER_IDLE) begin
            owner_nxt = OWNER_IDLE;
            cnt_nxt   = 4'd0;
        end else if (grant == owner) begin
            cnt_nxt   = sat_inc(cnt, BURST_LIM);
        end else begin
            owner_nxt = grant;
            cnt_nxt   = 4'd1;
            prio_nxt  = (grant == OWNER_A) ? PRIO_B : PRIO_A;
        end
    end

    // State register plus one-cycle read-valid pipeline per port.
    always_ff @(posedge clock) begin
        if (reset) begin
            owner  <= OWNER_IDLE;
            cnt    <= 4'd0;
            prio   <= PRIO_A;
            a_rv_q <= 1'b0;
            b_rv_q <= 1'b0;
        end else begin
            owner  <= owner_nxt;
            cnt    <= cnt_nxt;
            prio   <= prio_nxt;
            a_rv_q <= a_gnt & ~a_we;
            b_rv_q <= b_gnt & ~b_we;
        end
    end

    // A read granted just before reset must not surface while reset is high,
    // so the registered valids are masked by reset as well as cleared by it.
    assign a_rvalid = a_rv_q & ~reset;
    assign b_rvalid = b_rv_q & ~reset;

    // Both ports see the RAM output directly; rvalid says whose data it is.
    assign a_rdata = mem_q;
    assign b_rdata = mem_q;

endmodule

// File: doc/dram_port_arbiter.md
DRAM_PORT_ARBITER -- requirements
Module: dram_port_arbiter

Interface
REQ-001 Parameter AW, default 8: address width, sized to the 256-word data RAM.
REQ-002 Parameter DW, default 16: data width.
REQ-003 Parameter MAX_BURST, default 4: maximum consecutive grants to one owner while the other requester waits; legal range 1..15.
REQ-004 clock  in  1: single clock; every register updates on its rising edge.
REQ-005 reset  in  1: synchronous, active-high reset.
REQ-006 a_req, a_we  in  1 each: port A (processor) request; write when a_we=1, read when a_we=0.
REQ-007 a_addr  in  AW; a_wdata  in  DW: port A address and write data.
REQ-008 a_gnt  out  1: port A access issued this cycle.
REQ-009 a_rvalid  out  1; a_rdata  out  DW: port A read data valid.
REQ-010 b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata: port B (loader/debug), same widths and meaning as port A.
REQ-011 mem_address  out  AW; mem_data  out  DW; mem_wren  out  1: RAM port drive.
REQ-012 mem_q  in  DW: RAM read data, valid one cycle after the address is presented.

Function
REQ-013 State register `owner` ∈ {IDLE, OWN_A, OWN_B} holds the owner of the previous cycle's grant; IDLE means no grant last cycle.
REQ-014 Burst counter `cnt` (4 bits) holds the number of consecutive grants to the current owner; it saturates at MAX_BURST.
REQ-015 Priority bit `prio` (A=0, B=1) holds the winner for IDLE-state ties.
REQ-016 Grant is combinational in the request cycle; a_gnt and b_gnt are never both 1.
REQ-017 In OWN_X with X requesting, X is granted if the other port is idle or cnt < MAX_BURST; otherwise the other port is granted.
REQ-018 In OWN_X with X not requesting, the other port is granted if it requests; otherwise there is no grant.
REQ-019 In IDLE, a single requester is granted; if both request, the port named by prio is granted.
REQ-020 Next-state update:
- grant to the same owner: cnt = cnt+1 (saturating).
- grant to a new owner: owner updates, cnt=1, prio = the losing port.
- no grant: owner=IDLE, cnt=0.
REQ-021 mem_address, mem_data and mem_wren mux from the granted port; mem_wren = granted_we.
REQ-022 With no grant, mem_wren=0 and mem_address/mem_data hold the port A values.
REQ-023 A granted write completes at the end of its grant cycle and has no response.
REQ-024 A granted read in cycle N gives X_rvalid=1 in cycle N+1, registered, one cycle wide per read.
REQ-025 a_rdata and b_rdata both equal mem_q combinationally; data is meaningful only while the port's rvalid=1.
REQ-026 Back-to-back reads from either or alternating ports sustain one read per cycle with no bubble.
REQ-027 A read in cycle N+1 of an address written in cycle N returns the new data; this is inherent to the RAM's new-data read-during-write mode.
REQ-028 A requester keeps req, we, addr and wdata stable until it sees gnt; a request dropped before gnt is legal and silently abandoned.

Reset
REQ-029 While reset=1: a_gnt=b_gnt=0, mem_wren=0, and no RAM access occurs.
REQ-030 On the clock edge with reset=1: owner=IDLE, cnt=0, prio=A, a_rvalid=b_rvalid=0.
REQ-031 A read granted in the cycle before reset asserts produces no rvalid after reset.

Structure
REQ-032 Shared package dram_arb_pkg holds the owner state enumeration and the AW/DW default constants.
REQ-033 One sub-module is natural: dram_arb_pick, a purely combinational grant picker (owner, cnt, prio, reqs -> grant).
REQ-034 All registers live in dram_port_arbiter.

Verification
REQ-035 Lone reads: after reset, a_req=1, a_we=0, a_addr=0x10 for one cycle, RAM[0x10]=0xBEEF -> a_gnt=1 that cycle, then a_rvalid=1 with a_rdata=0xBEEF in the next cycle.
REQ-036 Contention: a_req and b_req held high for 12 cycles, MAX_BURST=4 -> grant sequence AAAABBBBAAAA; never both grants in one cycle.
REQ-037 Write then read: B writes 0x1234 to 0x20 in cycle N; A reads 0x20 in cycle N+1 -> a_rvalid=1 with a_rdata=0x1234 in cycle N+2.
REQ-038 IDLE tie: A holds the port 2 cycles, then one idle cycle, then both request -> B is granted, since prio=B after the A-to-B handover rule and the A win.
REQ-039 Reset mid-read: A read granted in cycle N, reset=1 in cycle N+1 -> a_rvalid=0 in N+1 and N+2, mem_wren=0 while reset=1, owner=IDLE afterwards.
REQ-040 Burst yield: MAX_BURST=1 with both ports writing continuously -> strict ABAB alternation; RAM contents match a reference model of the alternating writes.
